// File: rtl/symbol_framer_pkg.sv
// -----------------------------------------------------------------------------
// symbol_framer_pkg
// Shared parameters for the OFDM symbol framer: default frame geometry,
// sample width, FSM state encoding and a counter-width helper.
// Optional feature macro used by the framer: SYMBOL_FRAMER_SYMIDX_EN.
// -----------------------------------------------------------------------------
package symbol_framer_pkg;

    localparam int N_FFT_DEF = 64;   // samples per symbol body
    localparam int N_CP_DEF  = 16;   // cyclic-prefix samples dropped between symbols
    localparam int N_SYM_DEF = 4;    // symbols per frame
    localparam int DW_DEF    = 32;   // {I[31:16], Q[15:0]}
    localparam int UW        = 8;    // symbol-index sideband width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        SKIP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Width of a counter that counts 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/symbol_framer_axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// One-deep registered AXI-Stream slice. A beat presented while in_ready_o is
// high is captured and shown on the output the next cycle; it holds steady
// until the consumer takes it. Data register resets to zero.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid_i     upstream valid
//   in_ready_o     upstream ready (slot empty or draining this cycle)
//   in_data_i      upstream payload, W bits
//   out_valid_o    downstream valid
//   out_ready_i    downstream ready
//   out_data_o     downstream payload, W bits
// -----------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Slot register: refill or drain whenever the slot is free to change.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready_o) begin
                valid_q <= in_valid_i;
            end
            if (in_valid_i && in_ready_o) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/symbol_framer.sv
// -----------------------------------------------------------------------------
// symbol_framer
// After a fine-timing trigger, strips cyclic prefixes from the aligned I/Q
// stream and emits N_SYM packets of N_FFT samples (tlast on the final sample)
// toward the FFT. Samples outside a frame are discarded.
// Optional feature: define SYMBOL_FRAMER_SYMIDX_EN to add m_axis_tuser (8 bit
// symbol index, constant across a packet).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   trigger_tick          frame start, honoured only on an accepted beat in IDLE
//   s_axis_tdata/tvalid/tready   input sample stream
//   m_axis_tdata/tvalid/tready/tlast  output symbol packets
//   m_axis_tuser          symbol index (only with SYMBOL_FRAMER_SYMIDX_EN)
//   busy                  frame in progress
//   frame_done            pulse after the frame's final tlast beat is taken
// Assumes N_FFT >= 2 and N_SYM >= 1.
// -----------------------------------------------------------------------------
module symbol_framer
    import symbol_framer_pkg::*;
#(
    parameter int N_FFT = N_FFT_DEF,
    parameter int N_CP  = N_CP_DEF,
    parameter int N_SYM = N_SYM_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger_tick,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
`ifdef SYMBOL_FRAMER_SYMIDX_EN
    output logic [UW-1:0] m_axis_tuser,
`endif
    output logic          busy,
    output logic          frame_done
);

    localparam int SAW = cnt_w(N_FFT);
    localparam int SYW = cnt_w(N_SYM);
    localparam int SKW = cnt_w(N_CP);
    localparam logic [SAW-1:0] SAMP_LAST = SAW'(N_FFT - 1);
    localparam logic [SYW-1:0] SYM_LAST  = SYW'(N_SYM - 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((N_CP > 0) ? (N_CP - 1) : 0);
`ifdef SYMBOL_FRAMER_SYMIDX_EN
    localparam int PW = DW + 1 + UW;
`else
    localparam int PW = DW + 1;
`endif

    state_e         state_q, state_d;
    logic [SAW-1:0] samp_cnt_q, samp_cnt_d;
    logic [SYW-1:0] sym_cnt_q, sym_cnt_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic           frame_done_q, frame_done_d;

    logic           slc_in_valid_s;
    logic           slc_in_ready_s;
    logic           slc_last_s;
    logic [PW-1:0]  slc_in_data_s;
    logic [PW-1:0]  slc_out_data_s;
    logic           in_acc_s;
    logic           out_acc_s;

    assign in_acc_s  = s_axis_tvalid && s_axis_tready;
    assign out_acc_s = m_axis_tvalid && m_axis_tready;

`ifdef SYMBOL_FRAMER_SYMIDX_EN
    assign slc_in_data_s = {UW'(sym_cnt_q), slc_last_s, s_axis_tdata};
    assign m_axis_tuser  = slc_out_data_s[DW+UW:DW+1];
`else
    assign slc_in_data_s = {slc_last_s, s_axis_tdata};
`endif
    assign m_axis_tdata = slc_out_data_s[DW-1:0];
    assign m_axis_tlast = slc_out_data_s[DW];
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;

    // Next-state, counter update and input handshake for the framing FSM.
    always_comb begin
        state_d        = state_q;
        samp_cnt_d     = samp_cnt_q;
        sym_cnt_d      = sym_cnt_q;
        skip_cnt_d     = skip_cnt_q;
        frame_done_d   = 1'b0;
        s_axis_tready  = 1'b0;
        slc_in_valid_s = 1'b0;
        slc_last_s     = 1'b0;
        case (state_q)
            IDLE: begin
                s_axis_tready = 1'b1;
                // The triggering beat is already sample 0 of symbol 0.
                if (s_axis_tvalid && trigger_tick) begin
                    slc_in_valid_s = 1'b1;
                    state_d        = BODY;
                    samp_cnt_d     = SAW'(1);
                    sym_cnt_d      = '0;
                    skip_cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BODY: begin
                s_axis_tready  = slc_in_ready_s;
                slc_in_valid_s = s_axis_tvalid;
                if (in_acc_s) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        slc_last_s = 1'b1;
                        samp_cnt_d = '0;
                        if (sym_cnt_q == SYM_LAST) begin
                            state_d = DONE;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYW'(1);
                            state_d   = (N_CP == 0) ? BODY : SKIP;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAW'(1);
                    end
                end else begin
                    state_d = BODY;
                end
            end
            SKIP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        skip_cnt_d = '0;
                        state_d    = BODY;
                    end else begin
                        skip_cnt_d = skip_cnt_q + SKW'(1);
                    end
                end else begin
                    state_d = SKIP;
                end
            end
            DONE: begin
                // Only the final tlast beat can be in the slice here.
                if (out_acc_s && m_axis_tlast) begin
                    frame_done_d = 1'b1;
                    sym_cnt_d    = '0;
                    state_d      = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the frame_done pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    axis_reg_slice #(
        .W (PW)
    ) u_out_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (slc_in_valid_s),
        .in_ready_o  (slc_in_ready_s),
        .in_data_i   (slc_in_data_s),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (slc_out_data_s)
    );

endmodule

// File: tb/tb_symbol_framer.sv
module tb_symbol_framer;

    localparam int N_FFT = 64;
    localparam int N_CP  = 16;
    localparam int N_SYM = 2;
    localparam int DW    = 32;

    typedef struct packed {
        logic [7:0]  user;
        logic        fin;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger_tick;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
`ifdef SYMBOL_FRAMER_SYMIDX_EN
    logic [7:0]    m_axis_tuser;
`endif
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    symbol_framer #(
        .N_FFT (N_FFT),
        .N_CP  (N_CP),
        .N_SYM (N_SYM),
        .DW    (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger_tick  (trigger_tick),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef SYMBOL_FRAMER_SYMIDX_EN
        .m_axis_tuser  (m_axis_tuser),
`endif
        .busy          (busy),
        .frame_done    (frame_done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    logic [31:0] ramp    = 32'd0;
    logic [31:0] trig_a  = 32'hFFFF_FFFF;
    logic [31:0] trig_b  = 32'hFFFF_FFFF;
    logic [31:0] mark_val = 32'hFFFF_FFFF;
    bit          bp_en, lat_en, idle_chk, rst_chk;
    bit          fd_exp, fd_seen, seen_mark, prev_stall;
    logic [32:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        s_axis_tdata  = ramp;
        trigger_tick  = (ramp == trig_a) || (ramp == trig_b);
        m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Expected packets for a trigger on ramp value t: bodies separated by N_CP skipped samples.
    task automatic push_frame(input logic [31:0] t);
        exp_t e;
        for (int s = 0; s < N_SYM; s++) begin
            for (int i = 0; i < N_FFT; i++) begin
                e.user = 8'(s);
                e.last = (i == N_FFT - 1);
                e.fin  = (s == N_SYM - 1) && (i == N_FFT - 1);
                e.data = t + 32'(s * (N_FFT + N_CP)) + 32'(i);
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock: observe at negedge, then advance the ramp after the edge.
    task automatic step();
        exp_t e;
        bit   acc_in, acc_out;
        @(negedge clk);
        acc_in  = s_axis_tvalid && s_axis_tready;
        acc_out = m_axis_tvalid && m_axis_tready;
        if (rst_chk) begin
            chk("rst_mid_tvalid", m_axis_tvalid, 64'd0);
            chk("rst_mid_busy", busy, 64'd0);
            chk("rst_mid_tlast", m_axis_tlast, 64'd0);
            rst_chk = 1'b0;
        end
        if (idle_chk) begin
            chk("idle_srdy", s_axis_tready, 64'd1);
            chk("idle_mvalid", m_axis_tvalid, 64'd0);
        end
        if (!s_axis_tready) chk("srdy_low_without_hold", m_axis_tvalid, 64'd1);
        if (!busy) chk("srdy_not_busy", s_axis_tready, 64'd1);
        if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_out});
        chk("frame_done", frame_done, 64'(fd_exp));
        if (fd_exp) begin
            chk("busy_after_done", busy, 64'd0);
            fd_seen = 1'b1;
        end
        fd_exp = 1'b0;
        if (acc_out) begin
            if (lat_en) chk("latency", m_axis_tdata, s_axis_tdata - 32'd1);
            if (m_axis_tdata == mark_val) seen_mark = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", acc_out, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
`ifdef SYMBOL_FRAMER_SYMIDX_EN
                chk("tuser", m_axis_tuser, e.user);
`endif
                if (e.fin) fd_exp = 1'b1;
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tlast, m_axis_tdata};
        @(posedge clk);
        #1;
        if (acc_in) ramp = ramp + 32'd1;
        drive();
    endtask

    task automatic run_frame(input logic [31:0] t, input logic [31:0] spur);
        fd_seen = 1'b0;
        trig_a  = t;
        trig_b  = spur;
        push_frame(t);
        drive();
        for (int c = 0; c < 4000 && !fd_seen; c++) step();
        chk("frame_timeout", fd_seen, 64'd1);
        chk("drain", exp_q.size(), 64'd0);
        trig_a = 32'hFFFF_FFFF;
        trig_b = 32'hFFFF_FFFF;
        drive();
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        trigger_tick  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", m_axis_tvalid, 64'd0);
        chk("reset_tlast", m_axis_tlast, 64'd0);
        chk("reset_tdata", m_axis_tdata, 64'd0);
        chk("reset_busy", busy, 64'd0);
        chk("reset_frame_done", frame_done, 64'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b1;
        drive();

        // Ideal flow: trigger on 100, downstream always ready.
        lat_en = 1'b1;
        run_frame(32'd100, 32'hFFFF_FFFF);
        lat_en = 1'b0;

        // Spurious second trigger 30 samples into the first body.
        run_frame(ramp + 32'd20, ramp + 32'd50);

        // Random downstream backpressure.
        bp_en = 1'b1;
        drive();
        run_frame(ramp + 32'd20, 32'hFFFF_FFFF);
        bp_en = 1'b0;
        drive();

        // Reset mid-frame, 20 samples into the first packet.
        trig_a    = ramp + 32'd20;
        push_frame(trig_a);
        mark_val  = trig_a + 32'd20;
        seen_mark = 1'b0;
        drive();
        for (int c = 0; c < 500 && !seen_mark; c++) step();
        chk("mark_timeout", seen_mark, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        trig_a   = 32'hFFFF_FFFF;
        mark_val = 32'hFFFF_FFFF;
        rst_chk  = 1'b1;
        drive();
        step();
        run_frame(ramp + 32'd20, 32'hFFFF_FFFF);

        // Long idle stretch with no trigger.
        idle_chk = 1'b1;
        repeat (1000) step();
        idle_chk = 1'b0;
        chk("idle_no_output", exp_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
